// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: source count, APB register
// offsets and the arbitration FSM state encoding.
package irq_pkg;

    localparam int NUM_IRQ = 4;

    localparam logic [31:0] ADDR_MASK     = 32'h0000_0000;
    localparam logic [31:0] ADDR_PRIO     = 32'h0000_0004;
    localparam logic [31:0] ADDR_CTRL     = 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_000C;
    localparam logic [31:0] ADDR_PEND_CLR = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_SVC  = 2'd3
    } state_e;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner selection for the interrupt arbiter.
// Ports:
//   eligible_i : sources that may be granted this cycle
//   prio_i     : 2-bit priority per source (source n at [2n+1:2n], 3 = highest)
//   last_id_i  : search starts at last_id_i + 1 (pass 3 for a fixed
//                lowest-index tie-break)
//   valid_o    : at least one source is eligible
//   id_o       : winning source
module irq_prio_select
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0]   eligible_i,
    input  logic [2*NUM_IRQ-1:0] prio_i,
    input  logic [1:0]           last_id_i,
    output logic                 valid_o,
    output logic [1:0]           id_o
);

    logic [1:0] idx;
    logic [1:0] best;

    // Strict '>' keeps the first candidate found in search order on a tie.
    always_comb begin
        valid_o = 1'b0;
        id_o    = 2'd0;
        best    = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            idx = last_id_i + 2'd1 + 2'(k);
            if (eligible_i[idx] && (!valid_o || (prio_i[{idx, 1'b0} +: 2] > best))) begin
                valid_o = 1'b1;
                id_o    = idx;
                best    = prio_i[{idx, 1'b0} +: 2];
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Four-source interrupt arbiter with an APB register interface.
// Optional feature macro: IRQ_ARB_ROUND_ROBIN_EN (round-robin tie-break
// among equal priorities; default build uses lowest-index tie-break).
// Ports:
//   pclk_i, rst_i                 : clock, asynchronous active-high reset
//   psel_i/penable_i/pwrite_i     : APB control
//   paddr_i/pwdata_i/prdata_o     : APB address / write data / read data
//   pready_o (tied 1), pslverr_o  : APB response (error on unmapped address)
//   irq_req_i[3:0]                : level requests
//   irq_o, irq_id_o               : interrupt to CPU and granted source
//   irq_ack_i, irq_eoi_i          : CPU acknowledge / end-of-interrupt pulses
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        pclk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    input  logic [3:0]  irq_req_i,
    output logic        irq_o,
    output logic [1:0]  irq_id_o,
    input  logic        irq_ack_i,
    input  logic        irq_eoi_i
);

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [7:0] prio_q, prio_d;
    logic       ctrl_q, ctrl_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] insvc_q, insvc_d;
    logic [1:0] irq_id_q, irq_id_d;
    logic [7:0] tcnt_q, tcnt_d;

    logic        wr_en;
    logic        mapped;
    logic [31:0] rd_data;
    logic [3:0]  pend_clr;
    logic [3:0]  eligible;
    logic [3:0]  id_onehot;
    logic [3:0]  ack_mask;
    logic [3:0]  eoi_mask;
    logic        ack_take;
    logic        eoi_take;
    logic        grant;
    logic        timeout_hit;
    logic        win_valid;
    logic [1:0]  win_id;
    logic [1:0]  sel_last;
    logic        unused_wdata;

    assign unused_wdata = ^pwdata_i[31:8];

    assign wr_en     = psel_i & penable_i & pwrite_i;
    assign eligible  = ctrl_q ? (pend_q & mask_q & ~insvc_q) : 4'd0;
    assign id_onehot = 4'b0001 << irq_id_q;
    assign ack_mask  = ack_take ? id_onehot : 4'd0;
    assign eoi_mask  = eoi_take ? id_onehot : 4'd0;
    // The cycle that sees tcnt_q == ACK_TIMEOUT-1 is the last one with irq_o high.
    assign timeout_hit = (int'(tcnt_q) + 1) >= ACK_TIMEOUT;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [1:0] last_id_q, last_id_d;

    assign last_id_d = grant ? win_id : last_id_q;
    assign sel_last  = last_id_q;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            last_id_q <= 2'd3;
        end else begin
            last_id_q <= last_id_d;
        end
    end
`else
    // Searching from last_id + 1 = 0 gives the fixed lowest-index tie-break.
    assign sel_last = 2'd3;
`endif

    irq_prio_select u_sel (
        .eligible_i (eligible),
        .prio_i     (prio_q),
        .last_id_i  (sel_last),
        .valid_o    (win_valid),
        .id_o       (win_id)
    );

    // APB read path and address decode.
    always_comb begin
        mapped  = 1'b1;
        rd_data = 32'd0;
        case (paddr_i)
            ADDR_MASK:     rd_data = {28'd0, mask_q};
            ADDR_PRIO:     rd_data = {24'd0, prio_q};
            ADDR_CTRL:     rd_data = {31'd0, ctrl_q};
            ADDR_STATUS:   rd_data = {16'd0, tcnt_q, insvc_q, pend_q};
            ADDR_PEND_CLR: rd_data = 32'd0;
            default:       mapped  = 1'b0;
        endcase
    end

    assign prdata_o  = (psel_i & ~pwrite_i) ? rd_data : 32'd0;
    assign pslverr_o = psel_i & penable_i & ~mapped;
    assign pready_o  = 1'b1;

    // Register writes; a new request wins over any clear in the same cycle.
    always_comb begin
        mask_d   = mask_q;
        prio_d   = prio_q;
        ctrl_d   = ctrl_q;
        pend_clr = 4'd0;
        if (wr_en) begin
            case (paddr_i)
                ADDR_MASK:     mask_d   = pwdata_i[3:0];
                ADDR_PRIO:     prio_d   = pwdata_i[7:0];
                ADDR_CTRL:     ctrl_d   = pwdata_i[0];
                ADDR_PEND_CLR: pend_clr = pwdata_i[3:0];
                default:       ;
            endcase
        end
        pend_d  = (pend_q & ~(pend_clr | eoi_mask)) | irq_req_i;
        insvc_d = (insvc_q & ~eoi_mask) | ack_mask;
    end

    // Arbitration FSM; the timeout counter only runs while in REQ and reads 0 elsewhere.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        tcnt_d   = tcnt_q;
        ack_take = 1'b0;
        eoi_take = 1'b0;
        grant    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) state_d = ST_ARB;
            end
            ST_ARB: begin
                tcnt_d = 8'd0;
                if (win_valid) begin
                    state_d  = ST_REQ;
                    irq_id_d = win_id;
                    grant    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!ctrl_q) begin
                    state_d = ST_IDLE;
                    tcnt_d  = 8'd0;
                end else if (irq_ack_i) begin
                    state_d  = ST_SVC;
                    ack_take = 1'b1;
                    tcnt_d   = 8'd0;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    tcnt_d  = 8'd0;
                end else if (tcnt_q != 8'hFF) begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            ST_SVC: begin
                if (irq_eoi_i) begin
                    state_d  = ST_IDLE;
                    eoi_take = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= 4'd0;
            prio_q   <= 8'd0;
            ctrl_q   <= 1'b0;
            pend_q   <= 4'd0;
            insvc_q  <= 4'd0;
            irq_id_q <= 2'd0;
            tcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            prio_q   <= prio_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            irq_id_q <= irq_id_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign irq_o    = (state_q == ST_REQ);
    assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
`timescale 1ns/1ps
module tb_irq_arbiter;

    localparam int TO = 4;

    typedef enum int {K_GRANT, K_READ, K_DROP, K_LEVEL} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] val;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst_i = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  irq_req = 4'd0;
    logic        irq_o;
    logic [1:0]  irq_id_o;
    logic        irq_ack = 1'b0;
    logic        irq_eoi = 1'b0;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    irq_arbiter #(.ACK_TIMEOUT(TO)) dut (
        .pclk_i    (pclk),
        .rst_i     (rst_i),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_req_i (irq_req),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o),
        .irq_ack_i (irq_ack),
        .irq_eoi_i (irq_eoi)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string what, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL unexpected_%s: got 0x%0h, expected no such event", what, act);
    endtask

    task automatic expect_item(input kind_e k, input logic [31:0] v, input logic er,
                               input int c, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.err  = er;
        e.cyc  = c;
        e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an observable event.
    task automatic monitor_loop();
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge pclk);
            if (sb.size() != 0 && sb[0].kind == K_LEVEL) begin
                e = sb.pop_front();
                check(e.name, {29'd0, irq_id_o, irq_o}, e.val);
            end
            if (psel && penable && !pwrite) begin
                if (sb.size() != 0 && sb[0].kind == K_READ) begin
                    e = sb.pop_front();
                    check(e.name, prdata, e.val);
                    check({e.name, "_slverr"}, {31'd0, pslverr}, {31'd0, e.err});
                end else begin
                    unexpected("read", prdata);
                end
            end
            if (irq_o && !prev) begin
                if (sb.size() != 0 && sb[0].kind == K_GRANT) begin
                    e = sb.pop_front();
                    check(e.name, {30'd0, irq_id_o}, e.val);
                    if (e.cyc >= 0) check({e.name, "_cycle"}, cyc, e.cyc);
                end else begin
                    unexpected("grant", {30'd0, irq_id_o});
                end
            end
            if (!irq_o && prev && sb.size() != 0 && sb[0].kind == K_DROP) begin
                e = sb.pop_front();
                check(e.name, cyc, e.cyc);
            end
            prev = irq_o;
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        step();
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] v, input logic er,
                            input string n);
        expect_item(K_READ, v, er, -1, n);
        step();
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1;
        step();
        irq_eoi = 1'b0;
    endtask

    task automatic wait_irq(input string n);
        int k;
        k = 0;
        while (!irq_o && k < 20) begin
            step();
            k++;
        end
        if (!irq_o) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_wait: irq_o = 0 after 20 cycles, expected 1", n);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            step();
            k++;
        end
    endtask

    int c;
    logic [1:0] rr_exp [3];

    initial begin
        fork
            monitor_loop();
        join_none

`ifdef IRQ_ARB_ROUND_ROBIN_EN
        rr_exp[0] = 2'd1; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1;
`else
        rr_exp[0] = 2'd1; rr_exp[1] = 2'd1; rr_exp[2] = 2'd1;
`endif

        // Reset state
        expect_item(K_LEVEL, 32'd0, 1'b0, -1, "reset_irq");
        step(); step(); step();
        rst_i = 1'b0;
        apb_read(32'h00, 32'h0, 1'b0, "reset_mask");
        apb_read(32'h04, 32'h0, 1'b0, "reset_prio");
        apb_read(32'h08, 32'h0, 1'b0, "reset_ctrl");
        apb_read(32'h0C, 32'h0, 1'b0, "reset_status");

        // Single source, latency and ack/EOI handshake
        apb_write(32'h00, 32'hF);
        apb_write(32'h08, 32'h1);
        apb_read(32'h00, 32'hF, 1'b0, "mask_rb");
        step();
        irq_req = 4'h4;
        c = cyc;
        expect_item(K_GRANT, 32'd2, 1'b0, c + 3, "grant_src2");
        step();
        irq_req = 4'h0;
        wait_irq("src2");
        pulse_ack();
        apb_read(32'h0C, 32'h44, 1'b0, "status_svc2");
        pulse_eoi();
        apb_read(32'h0C, 32'h00, 1'b0, "status_done2");

        // Priority order: src0 (prio 3) beats src3 (prio 0)
        apb_write(32'h04, 32'h1B);
        step();
        irq_req = 4'h9;
        expect_item(K_GRANT, 32'd0, 1'b0, -1, "grant_prio_src0");
        step();
        irq_req = 4'h0;
        wait_irq("src0");
        pulse_eoi();
        pulse_ack();
        apb_read(32'h0C, 32'h19, 1'b0, "status_svc0");
        expect_item(K_GRANT, 32'd3, 1'b0, -1, "grant_prio_src3");
        pulse_eoi();
        wait_irq("src3");
        pulse_ack();
        pulse_eoi();
        apb_read(32'h0C, 32'h00, 1'b0, "status_done3");

        // Acknowledge timeout, pend kept, re-grant
        step();
        irq_req = 4'h2;
        c = cyc;
        expect_item(K_GRANT, 32'd1, 1'b0, c + 3, "grant_to_src1");
        expect_item(K_DROP, 32'd0, 1'b0, c + 7, "timeout_drop");
        expect_item(K_GRANT, 32'd1, 1'b0, c + 9, "regrant_src1");
        step();
        irq_req = 4'h0;
        drain(30);
        pulse_ack();
        apb_read(32'h0C, 32'h22, 1'b0, "status_after_to");
        pulse_eoi();

        // Equal priority tie-break with sources 1 and 2 held
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        apb_write(32'h00, 32'hF);
        apb_write(32'h08, 32'h1);
        step();
        irq_req = 4'h6;
        for (int i = 0; i < 3; i++) begin
            expect_item(K_GRANT, {30'd0, rr_exp[i]}, 1'b0, -1, $sformatf("tie_grant%0d", i));
            wait_irq($sformatf("tie%0d", i));
            pulse_ack();
            if (i == 2) begin
                irq_req = 4'h0;
                apb_write(32'h08, 32'h0);
            end
            pulse_eoi();
        end
        apb_write(32'h10, 32'hF);
        apb_read(32'h0C, 32'h00, 1'b0, "status_pend_clr");

        // Unmapped read and set-over-clear on PEND_CLR
        apb_read(32'h20, 32'h0, 1'b1, "unmapped_read");
        step();
        irq_req = 4'h1;
        apb_write(32'h10, 32'h1);
        irq_req = 4'h0;
        apb_read(32'h0C, 32'h01, 1'b0, "status_set_wins");

        // Reset asserted while in service
        expect_item(K_GRANT, 32'd0, 1'b0, -1, "grant_before_rst");
        apb_write(32'h08, 32'h1);
        wait_irq("pre_rst");
        pulse_ack();
        step();
        rst_i = 1'b1;
        expect_item(K_LEVEL, 32'd0, 1'b0, -1, "rst_svc_irq");
        apb_read(32'h0C, 32'h0, 1'b0, "rst_svc_status");
        apb_read(32'h00, 32'h0, 1'b0, "rst_svc_mask");
        apb_read(32'h08, 32'h0, 1'b0, "rst_svc_ctrl");
        apb_read(32'h04, 32'h0, 1'b0, "rst_svc_prio");
        step();
        rst_i = 1'b0;

        drain(50);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: event never observed, expected value 0x%0h", e.name, e.val);
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter ACK_TIMEOUT, default 255: cycles irq_o may stay unacknowledged before the grant is withdrawn.
REQ-003 pclk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-006 paddr_i  in  32, pwdata_i  in  32, prdata_o  out  32  APB address and data.
REQ-007 pready_o  out  1, tied 1; pslverr_o  out  1, high for one access phase on an unmapped address.
REQ-008 irq_req_i  in  4  level requests from four sources, synchronous to pclk_i.
REQ-009 irq_o  out  1  interrupt to CPU; irq_id_o  out  2  granted source.
REQ-010 irq_ack_i  in  1  CPU acknowledge pulse; irq_eoi_i  in  1  end-of-interrupt pulse.

Function
REQ-011 Registers: 0x00 MASK[3:0] (1 = enabled), 0x04 PRIO[7:0] (2 bits per source, 3 = highest), 0x08 CTRL[0] = global enable, 0x0C STATUS read-only {timeout_cnt[7:0] at [15:8], insvc[7:4], pend[3:0]}, 0x10 PEND_CLR write-1-to-clear.
REQ-012 Write on psel_i & penable_i & pwrite_i; read data is combinational on psel_i & ~pwrite_i; unmapped reads return 0.
REQ-013 pend[n] sets on irq_req_i[n] and holds until the EOI of source n or a PEND_CLR write; set has priority over clear in the same cycle.
REQ-014 Eligible sources: pend & MASK & ~insvc, only when CTRL[0] = 1.
REQ-015 Winner: highest PRIO; ties go to the lowest index.
REQ-016 States: IDLE, ARB, REQ, SVC.
REQ-017 IDLE -> ARB when any source is eligible.
REQ-018 ARB lasts one cycle, latches the winner into irq_id_o and goes to REQ; if nothing is eligible it returns to IDLE.
REQ-019 REQ: irq_o = 1, irq_id_o stable.
REQ-020 REQ exits to SVC on irq_ack_i and sets insvc[id].
REQ-021 REQ exits to IDLE after ACK_TIMEOUT cycles with no acknowledge; pend is kept.
REQ-022 REQ exits to IDLE when CTRL[0] is cleared.
REQ-023 Latency: request high at edge N gives irq_o = 1 after edge N+2.
REQ-024 SVC: irq_o = 0; irq_eoi_i clears insvc[id] and pend[id] and returns to IDLE; irq_ack_i is ignored.
REQ-025 irq_eoi_i outside SVC is ignored.
REQ-026 Clearing MASK[id] during REQ does not withdraw the grant.
REQ-027 The timeout counter is 8 bits, resets on entry to REQ and saturates; it never wraps.

Reset
REQ-028 Reset values: MASK = 0, PRIO = 0, CTRL = 0, pend = 0, insvc = 0, state = IDLE, irq_o = 0, irq_id_o = 0, prdata_o = 0, timeout counter = 0.
REQ-029 Reset asserted mid-handshake returns to IDLE immediately, with no EOI required.

Configuration
REQ-030 Macro IRQ_ARB_ROUND_ROBIN_EN defined: among equal-PRIO candidates, the search starts at the index after the last granted id, which is kept in a 2-bit register that resets to 3.
REQ-031 Macro IRQ_ARB_ROUND_ROBIN_EN absent: fixed lowest-index tie-break and no last-id register.

Structure
REQ-032 Shared package irq_pkg holds the register offsets, the state encoding and NUM_IRQ = 4.
REQ-033 Sub-module irq_prio_select holds the combinational winner selection (eligible, PRIO, last id -> valid, id).

Verification
REQ-034 MASK = 0xF, CTRL = 1, pulse irq_req_i = 0x4 -> irq_o = 1 two cycles later, id = 2; ack then EOI -> STATUS = 0.
REQ-035 PRIO = 0x1B (src0 = 3, src3 = 0), raise sources 0 and 3 together -> id 0 first; after EOI, id 3.
REQ-036 Request with no acknowledge, ACK_TIMEOUT = 4 -> irq_o drops after 4 cycles, pend kept, re-grant follows.
REQ-037 Macro defined, equal PRIO, sources 1 and 2 held -> grants alternate 1, 2, 1; macro absent -> 1, 1, 1.
REQ-038 Assert rst_i while in SVC -> irq_o = 0 and all registers at reset values in the same cycle.
REQ-039 APB read of 0x20 -> prdata_o = 0 and pslverr_o = 1; PEND_CLR write of 0x1 during a new src0 request -> pend[0] stays 1.
